// File: rtl/mux_ctrl_pkg.sv
// Shared constants and state encoding for the 8:1 mux round-robin arbiter.
// Holds the requester count, select width, FSM encoding and default hold limit.
package mux_ctrl_pkg;

    localparam int N_REQ        = 8;
    localparam int SEL_W        = 3;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational wrap-around first-set search over 8 requests.
// The search starts at i_ptr and wraps 7 -> 0.
module rr_pick8 (
    input  logic [7:0] i_req,
    input  logic [2:0] i_ptr,
    output logic [2:0] o_w,
    output logic       o_any
);

    logic [2:0] w_idx;

    // Scan from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        o_w   = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = 7; k >= 0; k--) begin
            w_idx = i_ptr + 3'(k);
            if (i_req[w_idx]) begin
                o_w   = w_idx;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 mux, one owner at a time.
// Optional forced rotation after HOLD_MAX cycles: define MUX8_RR_TIMEOUT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | no owner; GNT = 0, SEL holds the last owner
//   ST_BUSY | one owner holds GNT until it drops REQ (or timeout)
module mux8_rr_arbiter #(
    parameter int N_REQ = mux_ctrl_pkg::N_REQ
`ifdef MUX8_RR_TIMEOUT_EN
    , parameter int HOLD_MAX = mux_ctrl_pkg::HOLD_MAX_DEF
`endif
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [N_REQ-1:0]               i_req,
    output logic [N_REQ-1:0]               o_gnt,
    output logic [mux_ctrl_pkg::SEL_W-1:0] o_sel,
    output logic                           o_valid
`ifdef MUX8_RR_TIMEOUT_EN
    , output logic                         o_tout
`endif
);

    import mux_ctrl_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_gnt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic               r_valid;

    logic [N_REQ-1:0]   w_cand;
    logic [SEL_W-1:0]   w_win;
    logic               w_any;
    logic               w_owner_req;
    logic               w_expire;
    logic               w_load;
    logic               w_clear;
    logic               w_rot;

    // Masking the owner lets a forced rotation see only the other requesters.
    assign w_cand      = i_req & ~r_gnt;
    assign w_owner_req = |(i_req & r_gnt);

    rr_pick8 u_pick (
        .i_req (w_cand),
        .i_ptr (r_ptr),
        .o_w   (w_win),
        .o_any (w_any)
    );

`ifdef MUX8_RR_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_tout;

    assign w_expire = (r_cnt == 8'(HOLD_MAX - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_rot;
            if (w_load)
                r_cnt <= '0;
            else if (r_state == ST_BUSY && !w_expire)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tout = r_tout;
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
            ST_BUSY: if (!w_owner_req && !w_any) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        w_rot   = 1'b0;
        case (r_state)
            ST_IDLE: w_load = w_any;
            ST_BUSY: begin
                if (!w_owner_req) begin
                    w_load  = w_any;
                    w_clear = !w_any;
                end else if (w_expire && w_any) begin
                    w_load = 1'b1;
                    w_rot  = 1'b1;
                end
            end
            default: w_clear = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_gnt   <= N_REQ'(1) << w_win;
            r_sel   <= w_win;
            r_ptr   <= w_win + 3'd1;
            r_valid <= 1'b1;
        end else if (w_clear) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign o_gnt   = r_gnt;
    assign o_sel   = r_sel;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter, including an 8:1 mux model on SEL.
// Builds with or without MUX8_RR_TIMEOUT_EN (HOLD_MAX = 16 when defined).
module tb_mux8_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       valid;
   logic       tout;
   logic [7:0] mux_i;
   logic       mux_y;

   int n_chk = 0;
   int n_err = 0;

`ifdef MUX8_RR_TIMEOUT_EN
   mux8_rr_arbiter #(.N_REQ(8), .HOLD_MAX(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .o_gnt   (gnt),
      .o_sel   (sel),
      .o_valid (valid),
      .o_tout  (tout)
   );
`else
   mux8_rr_arbiter #(.N_REQ(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .o_gnt   (gnt),
      .o_sel   (sel),
      .o_valid (valid)
   );

   assign tout = 1'b0;
`endif

   assign mux_y = mux_i[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_gnt;
      logic       exp_tout;
      bit         y_exp [8];
      y_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      mux_i = 8'b1010_0101;
      rst_n = 1'b0;
      req   = 8'h00;

      #3;
      chk("reset_gnt",   gnt,          8'h00);
      chk("reset_sel",   {5'd0, sel},  8'h00);
      chk("reset_valid", {7'd0, valid},8'h00);
      chk("reset_tout",  {7'd0, tout}, 8'h00);
      #9 rst_n = 1'b1;

      // single requester, ptr 0 -> 4
      req = 8'h08; tick();
      chk("single_gnt",   gnt,           8'h08);
      chk("single_sel",   {5'd0, sel},   8'h03);
      chk("single_valid", {7'd0, valid}, 8'h01);
      req = 8'h00; tick();
      chk("release_gnt",   gnt,           8'h00);
      chk("release_sel",   {5'd0, sel},   8'h03);
      chk("release_valid", {7'd0, valid}, 8'h00);
      tick();
      chk("idle_hold_sel", {5'd0, sel},   8'h03);

      // owner 5 sets ptr to 6, then 0x81 arrives together
      req = 8'h20; tick();
      chk("g5_gnt", gnt, 8'h20);
      req = 8'h00; tick();
      chk("g5_rel_sel", {5'd0, sel}, 8'h05);
      req = 8'h81; tick();
      chk("wrap_gnt7", gnt,         8'h80);
      chk("wrap_sel7", {5'd0, sel}, 8'h07);
      req = 8'h01; tick();
      chk("wrap_gnt0",   gnt,           8'h01);
      chk("wrap_valid0", {7'd0, valid}, 8'h01);
      req = 8'h00; tick();

      // owner 7 moves ptr to 0 for the fairness sweep
      req = 8'h80; tick();
      chk("pre_fair_gnt", gnt, 8'h80);
      req = 8'h00; tick();
      chk("pre_fair_idle", gnt, 8'h00);
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("fair_sel_%0d", k), {5'd0, sel}, 8'(k % 8));
         chk($sformatf("fair_gnt_%0d", k), gnt, 8'h01 << (k % 8));
         chk($sformatf("fair_valid_%0d", k), {7'd0, valid}, 8'h01);
         req = ~(8'h01 << (k % 8));
      end
      req = 8'h00; tick();
      chk("post_fair_idle", gnt, 8'h00);

      // owner 2 holds while 4 waits; ptr is 1 here
      req = 8'h04; tick();
      chk("hold_first_gnt", gnt, 8'h04);
      req = 8'h14;
      for (int k = 1; k <= 40; k++) begin
         tick();
`ifdef MUX8_RR_TIMEOUT_EN
         exp_gnt  = ((k / 16) % 2 == 1) ? 8'h10 : 8'h04;
         exp_tout = (k % 16 == 0);
`else
         exp_gnt  = 8'h04;
         exp_tout = 1'b0;
`endif
         chk($sformatf("hold_gnt_%0d", k),  gnt,              exp_gnt);
         chk($sformatf("hold_tout_%0d", k), {7'd0, tout},     {7'd0, exp_tout});
      end
      req = 8'h10; tick();
      chk("handoff_gnt",  gnt,          8'h10);
      chk("handoff_sel",  {5'd0, sel},  8'h04);
      chk("handoff_tout", {7'd0, tout}, 8'h00);
      req = 8'h00; tick();
      chk("handoff_idle", {7'd0, valid}, 8'h00);

      // mux integration
      for (int i = 0; i < 8; i++) begin
         req = 8'h01 << i; tick();
         chk($sformatf("mux_sel_%0d", i), {5'd0, sel},   8'(i));
         chk($sformatf("mux_y_%0d", i),   {7'd0, mux_y}, {7'd0, y_exp[i]});
         req = 8'h00; tick();
      end

      // asynchronous reset in the middle of a grant to owner 5
      req = 8'h20; tick();
      chk("mid_gnt5", gnt, 8'h20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_gnt",   gnt,           8'h00);
      chk("async_rst_sel",   {5'd0, sel},   8'h00);
      chk("async_rst_valid", {7'd0, valid}, 8'h00);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_gnt",   gnt,           8'h20);
      chk("post_rst_sel",   {5'd0, sel},   8'h05);
      chk("post_rst_valid", {7'd0, valid}, 8'h01);
      req = 8'h00; tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
